// File: rtl/clk_div_pkg.sv
// Shared constants and channel state layout for the multi-channel clock divider.
package clk_div_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned MAX_CH        = 16;

    // Per-channel state at the default counter width
    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] cnt;
        logic [DEFAULT_WIDTH-1:0] active;
        logic [DEFAULT_WIDTH-1:0] pend_val;
        logic                     pend;
    } ch_state_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: programmable half-period, boundary-aligned reload, phase restart.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             inclk,
    input  logic             reset,
    input  logic [WIDTH-1:0] div_count_i,
    input  logic             load_i,
    input  logic             ch_en_i,
    input  logic             sync_restart_i,
    output logic             outclk_o,
    output logic             outclk_not_o,
    output logic             tick_o,
    output logic             pending_o
);

    typedef struct packed {
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] active;
        logic [WIDTH-1:0] pend_val;
        logic             pend;
    } chan_state_t;

    chan_state_t state_q, state_d;
    logic        outclk_q, outclk_d;
    logic        outclk_not_q, outclk_not_d;
    logic        tick_q, tick_d;
    logic        boundary;

    assign boundary = (state_q.active != '0) &&
                      (state_q.cnt == state_q.active - WIDTH'(1));

    always_comb begin
        state_d      = state_q;
        outclk_d     = outclk_q;
        outclk_not_d = outclk_not_q;
        tick_d       = 1'b0;

        if (!ch_en_i) begin
            state_d.cnt  = '0;
            outclk_d     = 1'b0;
            outclk_not_d = 1'b1;
        end else if (sync_restart_i) begin
            state_d.cnt  = '0;
            outclk_d     = 1'b0;
            outclk_not_d = 1'b1;
            // A load in the restart cycle takes effect immediately
            if (load_i) begin
                state_d.active   = div_count_i;
                state_d.pend_val = div_count_i;
                state_d.pend     = 1'b0;
            end else if (state_q.pend) begin
                state_d.active = state_q.pend_val;
                state_d.pend   = 1'b0;
            end
        end else if (state_q.active == '0) begin
            state_d.cnt  = '0;
            outclk_d     = 1'b0;
            outclk_not_d = 1'b1;
            if (state_q.pend) begin
                state_d.active = state_q.pend_val;
                state_d.pend   = 1'b0;
            end
        end else if (boundary) begin
            state_d.cnt = '0;
            if (state_q.pend && (state_q.pend_val == '0)) begin
                outclk_d     = 1'b0;
                outclk_not_d = 1'b1;
            end else begin
                outclk_d     = ~outclk_q;
                outclk_not_d = ~outclk_not_q;
                tick_d       = ~outclk_q;
            end
            if (state_q.pend) begin
                state_d.active = state_q.pend_val;
                state_d.pend   = 1'b0;
            end
        end else begin
            state_d.cnt = state_q.cnt + WIDTH'(1);
        end

        // A load not consumed by a restart waits for the next boundary
        if (load_i && !(ch_en_i && sync_restart_i)) begin
            state_d.pend_val = div_count_i;
            state_d.pend     = 1'b1;
        end
    end

    always_ff @(posedge inclk) begin
        if (reset) begin
            state_q      <= '0;
            outclk_q     <= 1'b0;
            outclk_not_q <= 1'b1;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            outclk_q     <= outclk_d;
            outclk_not_q <= outclk_not_d;
            tick_q       <= tick_d;
        end
    end

    assign outclk_o     = outclk_q;
    assign outclk_not_o = outclk_not_q;
    assign tick_o       = tick_q;
    assign pending_o    = state_q.pend;

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel clock divider: slices the buses and fans out restart to each channel.
module clk_divider_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = DEFAULT_WIDTH
) (
    input  logic                    inclk,
    input  logic                    reset,
    input  logic [NUM_CH*WIDTH-1:0] div_count,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    sync_restart,
    output logic [NUM_CH-1:0]       outclk,
    output logic [NUM_CH-1:0]       outclk_not,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       pending
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clk_div_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .inclk          (inclk),
            .reset          (reset),
            .div_count_i    (div_count[c*WIDTH +: WIDTH]),
            .load_i         (load[c]),
            .ch_en_i        (ch_en[c]),
            .sync_restart_i (sync_restart),
            .outclk_o       (outclk[c]),
            .outclk_not_o   (outclk_not[c]),
            .tick_o         (tick[c]),
            .pending_o      (pending[c])
        );
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi: table-driven basic divide plus corner sequences.
module tb_clk_divider_multi;

    localparam int unsigned NCH = 4;
    localparam int unsigned W   = 32;

    logic             inclk;
    logic             reset;
    logic [NCH*W-1:0] div_count;
    logic [NCH-1:0]   load;
    logic [NCH-1:0]   ch_en;
    logic             sync_restart;
    logic [NCH-1:0]   outclk;
    logic [NCH-1:0]   outclk_not;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   pending;

    int n_cmp = 0;
    int n_bad = 0;

    clk_divider_multi #(.NUM_CH(NCH), .WIDTH(W)) dut (
        .inclk        (inclk),
        .reset        (reset),
        .div_count    (div_count),
        .load         (load),
        .ch_en        (ch_en),
        .sync_restart (sync_restart),
        .outclk       (outclk),
        .outclk_not   (outclk_not),
        .tick         (tick),
        .pending      (pending)
    );

    initial inclk = 1'b0;
    always #5 inclk = ~inclk;

    typedef struct {
        logic        ld;
        logic [31:0] div;
        logic        exp_out;
        logic        exp_tick;
        logic        exp_pend;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock edge; strobes are single-cycle
    task automatic step();
        @(posedge inclk);
        #1;
        load         = '0;
        sync_restart = 1'b0;
    endtask

    task automatic set_div(input int c, input logic [31:0] v);
        div_count[c*W +: W] = v;
    endtask

    // Checks outclk/outclk_not/tick of masked channels against MSB-first patterns
    task automatic wave(input string nm, input int n, input logic [3:0] mask,
                        input logic [63:0] p0, input logic [63:0] p1,
                        input logic [63:0] p2, input logic [63:0] p3,
                        input logic [3:0] prev);
        logic [63:0] pat [4];
        logic [3:0]  p;
        logic        e, ne, te;
        pat[0] = p0; pat[1] = p1; pat[2] = p2; pat[3] = p3;
        p = prev;
        for (int i = 0; i < n; i++) begin
            step();
            for (int c = 0; c < 4; c++) begin
                if (mask[c]) begin
                    e  = pat[c][n-1-i];
                    ne = ~e;
                    te = e & ~p[c];
                    chk($sformatf("%s.out%0d[%0d]", nm, c, i), 32'(outclk[c]), 32'(e));
                    chk($sformatf("%s.not%0d[%0d]", nm, c, i), 32'(outclk_not[c]), 32'(ne));
                    chk($sformatf("%s.tick%0d[%0d]", nm, c, i), 32'(tick[c]), 32'(te));
                    p[c] = e;
                end
            end
        end
    endtask

    initial begin
        logic ne;
        tbl[0] = '{1'b1, 32'd2, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b0};

        reset        = 1'b1;
        div_count    = '0;
        load         = '0;
        ch_en        = '1;
        sync_restart = 1'b0;
        step();
        step();
        chk("rst.outclk",     32'(outclk),     32'h0);
        chk("rst.outclk_not", 32'(outclk_not), 32'hF);
        chk("rst.tick",       32'(tick),       32'h0);
        chk("rst.pending",    32'(pending),    32'h0);
        reset = 1'b0;

        // Load N=2 on idle ch0: period 4, 50% duty
        for (int i = 0; i < 9; i++) begin
            load[0] = tbl[i].ld;
            set_div(0, tbl[i].div);
            step();
            ne = ~tbl[i].exp_out;
            chk($sformatf("tbl%0d.out0", i),  32'(outclk[0]),     32'(tbl[i].exp_out));
            chk($sformatf("tbl%0d.not0", i),  32'(outclk_not[0]), 32'(ne));
            chk($sformatf("tbl%0d.tick0", i), 32'(tick[0]),       32'(tbl[i].exp_tick));
            chk($sformatf("tbl%0d.pend0", i), 32'(pending[0]),    32'(tbl[i].exp_pend));
        end

        // Ch0 restarted at N=5, then reloaded with N=2 at cnt=1
        set_div(0, 32'd5);
        load[0] = 1'b1;
        sync_restart = 1'b1;
        step();
        chk("reload.out0_s",  32'(outclk[0]),  32'h0);
        chk("reload.pend0_s", 32'(pending[0]), 32'h0);
        wave("reload_a", 6, 4'b0001, 64'b000011, 64'h0, 64'h0, 64'h0, 4'b0000);
        set_div(0, 32'd2);
        load[0] = 1'b1;
        step();
        chk("reload.out0_l",  32'(outclk[0]),  32'h1);
        chk("reload.pend0_l", 32'(pending[0]), 32'h1);
        wave("reload_b", 2, 4'b0001, 64'b11, 64'h0, 64'h0, 64'h0, 4'b0001);
        chk("reload.pend0_hold", 32'(pending[0]), 32'h1);
        wave("reload_c", 6, 4'b0001, 64'b001100, 64'h0, 64'h0, 64'h0, 4'b0001);
        chk("reload.pend0_done", 32'(pending[0]), 32'h0);

        // Ch0 N=3 and ch1 N=7 free-running, then phase-aligned restart
        set_div(0, 32'd3);
        set_div(1, 32'd7);
        load[1:0] = 2'b11;
        for (int i = 0; i < 5; i++) step();
        sync_restart = 1'b1;
        wave("restart", 8, 4'b1111, 64'b00011100, 64'b00000001, 64'h0, 64'h0, 4'b0000);
        chk("restart.pend", 32'(pending), 32'h0);

        // Ch2 N=1 divides by two; loading 0 stops it at the next boundary
        set_div(2, 32'd1);
        load[2] = 1'b1;
        step();
        chk("n1.pend2", 32'(pending[2]), 32'h1);
        chk("n1.out2",  32'(outclk[2]),  32'h0);
        wave("n1", 4, 4'b0100, 64'h0, 64'h0, 64'b0101, 64'h0, 4'b0000);
        set_div(2, 32'd0);
        load[2] = 1'b1;
        step();
        chk("stop.out2",  32'(outclk[2]),  32'h0);
        chk("stop.pend2", 32'(pending[2]), 32'h1);
        wave("stop", 5, 4'b0100, 64'h0, 64'h0, 64'b00000, 64'h0, 4'b0000);
        chk("stop.pend2_done", 32'(pending[2]), 32'h0);

        // Ch3 disabled while loaded, then re-enabled
        ch_en[3] = 1'b0;
        step();
        set_div(3, 32'd4);
        load[3] = 1'b1;
        step();
        chk("dis.pend3", 32'(pending[3]), 32'h1);
        chk("dis.out3",  32'(outclk[3]),  32'h0);
        wave("dis", 3, 4'b1000, 64'h0, 64'h0, 64'h0, 64'b000, 4'b0000);
        chk("dis.pend3_hold", 32'(pending[3]), 32'h1);
        ch_en[3] = 1'b1;
        wave("en", 6, 4'b1000, 64'h0, 64'h0, 64'h0, 64'b000011, 4'b0000);
        chk("en.pend3", 32'(pending[3]), 32'h0);

        // Reset mid-count with a pending value on ch1
        set_div(1, 32'd5);
        load[1] = 1'b1;
        step();
        chk("mid.pend1", 32'(pending[1]), 32'h1);
        reset = 1'b1;
        step();
        chk("mid.outclk",     32'(outclk),     32'h0);
        chk("mid.outclk_not", 32'(outclk_not), 32'hF);
        chk("mid.tick",       32'(tick),       32'h0);
        chk("mid.pending",    32'(pending),    32'h0);
        reset = 1'b0;
        wave("idle", 10, 4'b1111, 64'h0, 64'h0, 64'h0, 64'h0, 4'b0000);
        chk("idle.pending", 32'(pending), 32'h0);
        set_div(1, 32'd1);
        load[1] = 1'b1;
        step();
        chk("relaunch.pend1", 32'(pending[1]), 32'h1);
        wave("relaunch", 3, 4'b0010, 64'h0, 64'b010, 64'h0, 64'h0, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
